uart_cmd_decoder: RTL and testbench
===================================

# uart_cmd_decoder

Receive-side companion of the FIFO-to-UART streaming controller: pulls bytes from the UART receiver buffer, parses short ASCII command frames from the host, and drives the capture configuration (trigger mask, sample clock divider, arm and soft-reset strobes). It sits between the UART RX buffer and the trigger block and clock divider. It owns the UART unload strobe, so no other block reads RX data.

## Interface
Parameters:
- TO_W, 26, width of the inter-byte timeout counter.
- TIMEOUT_CYCLES, 50_000_000, idle cycles allowed between bytes of one frame.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- uart_rxdata  in  8  UART receive buffer data.
- uart_rxempty  in  1  high when the UART RX buffer is empty.
- uart_uld_rx_data  out  1  one-cycle unload strobe to the UART.
- trig_mask  out  3  trigger input mask; reset value 3'b111.
- clk_div  out  8  sample clock divider; reset value 8'h00.
- arm_pulse  out  1  one-cycle strobe that re-arms capture.
- soft_rst_pulse  out  1  one-cycle strobe that resets the capture path.
- cmd_error  out  1  one-cycle strobe on a malformed frame or timeout.
- err_count  out  8  saturating error counter; reset value 0.
- state_debug  out  4  current parser state encoding.

## Operation
Frame grammar, uppercase ASCII only, terminated by LF (0x0A):
- 'M' d LF: d is '0'..'7'; trig_mask <= d-'0'.
- 'D' h h LF: two hex digits, '0'..'9' or 'A'..'F', high nibble first; clk_div <= value.
- 'A' LF: arm_pulse.
- 'R' LF: soft_rst_pulse. trig_mask and clk_div are left unchanged.

Parsing rules:
- CR (0x0D) is dropped anywhere in a frame and refreshes the timeout.
- A bare LF in CMD_WAIT is ignored; it is not an error.
- Configuration changes are atomic. Operands go into shadow registers, and trig_mask, clk_div and the pulses update only when the terminating LF is accepted.
- Any byte that breaks the grammar causes a cmd_error pulse and entry to DISCARD. This covers unknown command letters, invalid digits, a non-LF byte where LF is expected, and an early LF. An early LF returns directly to CMD_WAIT.
- DISCARD drops bytes until an LF arrives, then goes to CMD_WAIT. Only one error is counted per frame.
- err_count increments on each cmd_error pulse and saturates at 255.

Byte fetch sub-FSM:
- F_IDLE: when uart_rxempty=0, go to F_ULD.
- F_ULD: assert uart_uld_rx_data for exactly one cycle.
- F_LATCH: sample uart_rxdata and present the byte to the parser as byte_valid.
- F_WAIT: hold until uart_rxempty=1, then go to F_IDLE.
- This guarantees one unload per received byte. No unload is ever issued while uart_rxempty=1.

Parser states: CMD_WAIT, ARG1, ARG2 (second hex digit, 'D' only), EXPECT_LF, DISCARD.

Timeout:
- The counter runs in every state except CMD_WAIT and clears on each accepted byte.
- When it reaches TIMEOUT_CYCLES, the frame is dropped and the parser returns to CMD_WAIT.
- A timeout raises cmd_error only if the parser was not already in DISCARD.

## Timing
- Reset: all outputs go to their listed reset values. Strobes are 0, parser is in CMD_WAIT, fetch is in F_IDLE, shadow registers and timeout are cleared. A frame in progress when reset is applied is lost with no error raised.
- Unload latency: uart_uld_rx_data rises 1 cycle after uart_rxempty is first sampled low.
- Byte capture: the data byte is captured in the cycle after the strobe (F_LATCH).
- Commit: register updates and pulses take effect on the clock edge that ends the F_LATCH cycle of the LF byte. arm_pulse, soft_rst_pulse and cmd_error are high for exactly that one following cycle.
- Error timing: cmd_error for a bad byte follows the same edge rule as a commit.
- Timeout timing: cmd_error for a timeout is asserted the cycle after the counter equals TIMEOUT_CYCLES.
- Collision: if a byte is latched in the same cycle the counter reaches TIMEOUT_CYCLES, the byte wins. The timeout is cancelled and the byte is parsed normally.
- Throughput: at most one byte per 4 cycles (F_IDLE to F_WAIT minimum), which is far above any UART rate.
- Stuck UART: if uart_rxempty never rises after an unload, fetch holds in F_WAIT. The parser timeout still recovers a partial frame.

## Test plan
- Reset state: after reset, trig_mask=3'b111, clk_div=0 and err_count=0. Send "M5\n": trig_mask becomes 3'b101 one cycle after the LF latch, with exactly three uld strobes and no cmd_error.
- Divider with CR: send "D3C\r\n": clk_div=8'h3C. Then send "D3G\n": cmd_error pulses once on 'G', clk_div stays 8'h3C, err_count=1, and the parser returns to CMD_WAIT after the LF.
- Strobes and idle LF: send "A\n" then "R\n": arm_pulse and soft_rst_pulse each go high for one cycle, trig_mask and clk_div are unchanged, and a bare "\n" produces no error.
- Timeout: with TIMEOUT_CYCLES=100, send "M" and hold uart_rxempty=1 for 150 cycles. cmd_error pulses at cycle 101 after the byte; a following "M2\n" sets trig_mask=3'b010.
- Saturation and mid-frame reset: 300 "X\n" frames give err_count=255. Asserting rst between "D4" and LF leaves clk_div=0 and err_count=0 with no pulses.

Source files
------------

// File: rtl/uart_cmd_decoder.sv
// rtl/uart_cmd_decoder.sv - ASCII command frame parser that drives the capture configuration
//
// Pulls bytes from a single-entry UART RX buffer, parses 'M' d LF, 'D' h h LF,
// 'A' LF and 'R' LF frames, and updates trig_mask / clk_div or fires the
// arm / soft-reset strobes when the terminating LF is accepted.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   uart_rxdata       UART receive buffer data
//   uart_rxempty      UART receive buffer empty flag
//   uart_uld_rx_data  one-cycle unload strobe to the UART
//   trig_mask         trigger input mask (reset 3'b111)
//   clk_div           sample clock divider (reset 8'h00)
//   arm_pulse         one-cycle capture re-arm strobe
//   soft_rst_pulse    one-cycle capture-path reset strobe
//   cmd_error         one-cycle strobe on malformed frame or timeout
//   err_count         saturating error counter
//   state_debug       parser state: 0 CMD_WAIT, 1 ARG1, 2 ARG2, 3 EXPECT_LF, 4 DISCARD
module uart_cmd_decoder #(
   parameter int TO_W           = 26,
   parameter int TIMEOUT_CYCLES = 50_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] uart_rxdata,
   input  logic       uart_rxempty,
   output logic       uart_uld_rx_data,
   output logic [2:0] trig_mask,
   output logic [7:0] clk_div,
   output logic       arm_pulse,
   output logic       soft_rst_pulse,
   output logic       cmd_error,
   output logic [7:0] err_count,
   output logic [3:0] state_debug
);

   localparam logic [7:0] CH_LF = 8'h0A;
   localparam logic [7:0] CH_CR = 8'h0D;
   localparam logic [7:0] CH_M  = 8'h4D;
   localparam logic [7:0] CH_D  = 8'h44;
   localparam logic [7:0] CH_A  = 8'h41;
   localparam logic [7:0] CH_R  = 8'h52;

   localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      F_IDLE  = 2'd0,
      F_ULD   = 2'd1,
      F_LATCH = 2'd2,
      F_WAIT  = 2'd3
   } fetch_t;

   typedef enum logic [3:0] {
      CMD_WAIT  = 4'd0,
      ARG1      = 4'd1,
      ARG2      = 4'd2,
      EXPECT_LF = 4'd3,
      DISCARD   = 4'd4
   } pstate_t;

   typedef enum logic [1:0] {
      C_MASK = 2'd0,
      C_DIV  = 2'd1,
      C_ARM  = 2'd2,
      C_RST  = 2'd3
   } cmd_t;

   function automatic logic is_hex(input logic [7:0] b);
      return ((b >= 8'h30) && (b <= 8'h39)) || ((b >= 8'h41) && (b <= 8'h46));
   endfunction

   // '0'..'9' map through the low nibble; 'A'..'F' (0x41..0x46) need +9.
   function automatic logic [3:0] hex_val(input logic [7:0] b);
      if (b <= 8'h39) begin
         return b[3:0];
      end
      return b[3:0] + 4'd9;
   endfunction

   // ------------------------------------------------------------------
   // Byte fetch FSM
   // ------------------------------------------------------------------
   fetch_t fetch_q;
   fetch_t fetch_d;

   logic       byte_valid;
   logic [7:0] rx_byte;

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_q <= F_IDLE;
      end else begin
         fetch_q <= fetch_d;
      end
   end

   always_comb begin
      fetch_d = fetch_q;
      case (fetch_q)
         F_IDLE:  if (!uart_rxempty) fetch_d = F_ULD;
         F_ULD:   fetch_d = F_LATCH;
         F_LATCH: fetch_d = F_WAIT;
         // Waiting for empty before returning keeps one unload per byte,
         // even if the UART is slow to drop its flag.
         F_WAIT:  if (uart_rxempty) fetch_d = F_IDLE;
         default: fetch_d = F_IDLE;
      endcase
   end

   always_comb begin
      uart_uld_rx_data = (fetch_q == F_ULD);
      byte_valid       = (fetch_q == F_LATCH);
      rx_byte          = uart_rxdata;
   end

   // ------------------------------------------------------------------
   // Parser
   // ------------------------------------------------------------------
   pstate_t         pstate_q;
   pstate_t         pstate_d;
   cmd_t            cmd_q;
   cmd_t            cmd_d;
   logic [7:0]      shadow_q;
   logic [7:0]      shadow_d;
   logic [TO_W-1:0] to_cnt;

   logic is_lf;
   logic is_cr;
   logic is_hex_b;
   logic is_oct;
   logic timeout_hit;
   logic frame_err;
   logic commit;

   always_comb begin
      is_lf    = (rx_byte == CH_LF);
      is_cr    = (rx_byte == CH_CR);
      is_hex_b = is_hex(rx_byte);
      is_oct   = (rx_byte >= 8'h30) && (rx_byte <= 8'h37);
      // A byte latched in the same cycle cancels the timeout.
      timeout_hit = (pstate_q != CMD_WAIT) && (to_cnt == TO_LIMIT) && !byte_valid;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pstate_q <= CMD_WAIT;
      end else begin
         pstate_q <= pstate_d;
      end
   end

   always_comb begin
      pstate_d = pstate_q;
      if (timeout_hit) begin
         pstate_d = CMD_WAIT;
      end else if (byte_valid && !is_cr) begin
         case (pstate_q)
            CMD_WAIT: begin
               if (is_lf) begin
                  pstate_d = CMD_WAIT;
               end else if ((rx_byte == CH_M) || (rx_byte == CH_D)) begin
                  pstate_d = ARG1;
               end else if ((rx_byte == CH_A) || (rx_byte == CH_R)) begin
                  pstate_d = EXPECT_LF;
               end else begin
                  pstate_d = DISCARD;
               end
            end
            ARG1: begin
               if (is_lf) begin
                  pstate_d = CMD_WAIT;
               end else if (cmd_q == C_MASK) begin
                  pstate_d = is_oct ? EXPECT_LF : DISCARD;
               end else begin
                  pstate_d = is_hex_b ? ARG2 : DISCARD;
               end
            end
            ARG2: begin
               if (is_lf) begin
                  pstate_d = CMD_WAIT;
               end else begin
                  pstate_d = is_hex_b ? EXPECT_LF : DISCARD;
               end
            end
            EXPECT_LF: pstate_d = is_lf ? CMD_WAIT : DISCARD;
            DISCARD:   if (is_lf) pstate_d = CMD_WAIT;
            default:   pstate_d = CMD_WAIT;
         endcase
      end
   end

   always_comb begin
      frame_err = 1'b0;
      commit    = 1'b0;
      cmd_d     = cmd_q;
      shadow_d  = shadow_q;
      if (timeout_hit) begin
         // A frame already in DISCARD has been counted once.
         frame_err = (pstate_q != DISCARD);
      end else if (byte_valid && !is_cr) begin
         case (pstate_q)
            CMD_WAIT: begin
               if (!is_lf) begin
                  case (rx_byte)
                     CH_M:    cmd_d = C_MASK;
                     CH_D:    cmd_d = C_DIV;
                     CH_A:    cmd_d = C_ARM;
                     CH_R:    cmd_d = C_RST;
                     default: frame_err = 1'b1;
                  endcase
               end
            end
            ARG1: begin
               if (is_lf) begin
                  frame_err = 1'b1;
               end else if (cmd_q == C_MASK) begin
                  if (is_oct) shadow_d = {5'b00000, rx_byte[2:0]};
                  else        frame_err = 1'b1;
               end else begin
                  if (is_hex_b) shadow_d = {hex_val(rx_byte), 4'h0};
                  else          frame_err = 1'b1;
               end
            end
            ARG2: begin
               if (is_hex_b) shadow_d[3:0] = hex_val(rx_byte);
               else          frame_err = 1'b1;
            end
            EXPECT_LF: begin
               if (is_lf) commit = 1'b1;
               else       frame_err = 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_q          <= C_MASK;
         shadow_q       <= 8'h00;
         to_cnt         <= '0;
         trig_mask      <= 3'b111;
         clk_div        <= 8'h00;
         arm_pulse      <= 1'b0;
         soft_rst_pulse <= 1'b0;
         cmd_error      <= 1'b0;
         err_count      <= 8'h00;
      end else begin
         cmd_q    <= cmd_d;
         shadow_q <= shadow_d;

         // Every accepted byte (CR included) restarts the inter-byte window.
         if (byte_valid || (pstate_q == CMD_WAIT)) begin
            to_cnt <= '0;
         end else if (to_cnt != TO_LIMIT) begin
            to_cnt <= to_cnt + TO_W'(1);
         end

         arm_pulse      <= commit && (cmd_q == C_ARM);
         soft_rst_pulse <= commit && (cmd_q == C_RST);
         cmd_error      <= frame_err;

         if (commit && (cmd_q == C_MASK)) trig_mask <= shadow_q[2:0];
         if (commit && (cmd_q == C_DIV))  clk_div   <= shadow_q;

         if (frame_err && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
         end
      end
   end

   assign state_debug = pstate_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb/tb_uart_cmd_decoder.sv - self-checking bench for uart_cmd_decoder
module tb_uart_cmd_decoder;

   localparam int TO_CYC = 100;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] uart_rxdata = 8'h00;
   logic       uart_rxempty = 1'b1;
   logic       uart_uld_rx_data;
   logic [2:0] trig_mask;
   logic [7:0] clk_div;
   logic       arm_pulse;
   logic       soft_rst_pulse;
   logic       cmd_error;
   logic [7:0] err_count;
   logic [3:0] state_debug;

   uart_cmd_decoder #(.TO_W(8), .TIMEOUT_CYCLES(TO_CYC)) dut (
      .clk              (clk),
      .rst              (rst),
      .uart_rxdata      (uart_rxdata),
      .uart_rxempty     (uart_rxempty),
      .uart_uld_rx_data (uart_uld_rx_data),
      .trig_mask        (trig_mask),
      .clk_div          (clk_div),
      .arm_pulse        (arm_pulse),
      .soft_rst_pulse   (soft_rst_pulse),
      .cmd_error        (cmd_error),
      .err_count        (err_count),
      .state_debug      (state_debug)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Strobe monitor
   int uld_cnt = 0, err_pulses = 0, arm_cnt = 0, srst_cnt = 0;
   int bad_uld = 0, bad_pulse = 0;
   logic prev_arm = 1'b0, prev_srst = 1'b0, prev_err = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         prev_arm = 1'b0; prev_srst = 1'b0; prev_err = 1'b0;
      end else begin
         if (uart_uld_rx_data) begin
            uld_cnt++;
            if (uart_rxempty) bad_uld++;
         end
         if (arm_pulse) begin arm_cnt++; if (prev_arm) bad_pulse++; end
         if (soft_rst_pulse) begin srst_cnt++; if (prev_srst) bad_pulse++; end
         if (cmd_error) begin err_pulses++; if (prev_err) bad_pulse++; end
         prev_arm = arm_pulse; prev_srst = soft_rst_pulse; prev_err = cmd_error;
      end
   end

   // Reference model: whole frames are judged against the grammar on LF
   logic [2:0]   m_mask = 3'b111;
   logic [7:0]   m_div = 8'h00;
   logic [7:0]   m_errcnt = 8'h00;
   int           m_errs = 0, m_arms = 0, m_srsts = 0;
   byte unsigned fbuf[$];

   function automatic bit hexc(input byte unsigned c);
      return (c >= "0" && c <= "9") || (c >= "A" && c <= "F");
   endfunction

   function automatic int hexv(input byte unsigned c);
      return (c <= "9") ? int'(c) - 48 : int'(c) - 55;
   endfunction

   task automatic model_reset();
      m_mask = 3'b111; m_div = 8'h00; m_errcnt = 8'h00;
      fbuf.delete();
   endtask

   task automatic model_err();
      m_errs++;
      if (m_errcnt != 8'hFF) m_errcnt = m_errcnt + 8'd1;
   endtask

   task automatic model_byte(input byte unsigned b);
      int n;
      if (b == 8'h0D) return;
      if (b != 8'h0A) begin
         fbuf.push_back(b);
         return;
      end
      n = fbuf.size();
      if (n == 0) begin
      end else if (n == 1 && fbuf[0] == "A") begin
         m_arms++;
      end else if (n == 1 && fbuf[0] == "R") begin
         m_srsts++;
      end else if (n == 2 && fbuf[0] == "M" && fbuf[1] >= "0" && fbuf[1] <= "7") begin
         m_mask = 3'(int'(fbuf[1]) - 48);
      end else if (n == 3 && fbuf[0] == "D" && hexc(fbuf[1]) && hexc(fbuf[2])) begin
         m_div = 8'(hexv(fbuf[1]) * 16 + hexv(fbuf[2]));
      end else begin
         model_err();
      end
      fbuf.delete();
   endtask

   // Offers one byte to the single-entry UART buffer; returns at the negedge
   // of the cycle after the unload strobe, with lat = cycles from load to strobe.
   task automatic send_byte(input byte unsigned b, output int lat);
      bit seen = 0;
      lat = 0;
      @(negedge clk);
      uart_rxdata = b;
      uart_rxempty = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         lat = i + 1;
         if (uart_uld_rx_data) seen = 1;
      end
      vectors++;
      if (!seen) begin
         miscompares++;
         $display("FAIL uld_wait: no unload strobe for byte %02h, required one within 20 cycles", b);
         uart_rxempty = 1'b1;
      end else begin
         #1 uart_rxempty = 1'b1;
         @(negedge clk);
      end
      model_byte(b);
   endtask

   task automatic send_str(input string s);
      int lat;
      for (int i = 0; i < s.len(); i++) begin
         send_byte(s[i], lat);
         repeat ($urandom_range(1, 4)) @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; uart_rxempty = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      vectors++; if (trig_mask !== 3'b111) begin miscompares++; $display("FAIL rst_mask: got %b required 111", trig_mask); end
      vectors++; if (clk_div !== 8'h00) begin miscompares++; $display("FAIL rst_div: got %h required 00", clk_div); end
      vectors++; if (err_count !== 8'h00) begin miscompares++; $display("FAIL rst_errcnt: got %h required 00", err_count); end
      vectors++; if ({arm_pulse, soft_rst_pulse, cmd_error, uart_uld_rx_data} !== 4'b0000) begin
         miscompares++; $display("FAIL rst_strobes: got %b required 0000", {arm_pulse, soft_rst_pulse, cmd_error, uart_uld_rx_data});
      end
      vectors++; if (state_debug !== 4'd0) begin miscompares++; $display("FAIL rst_state: got %0d required 0", state_debug); end
   endtask

   task automatic test_mask();
      int u0 = uld_cnt, e0 = err_pulses, lat;
      send_byte("M", lat);
      vectors++; if (lat != 1) begin miscompares++; $display("FAIL uld_latency: got %0d cycles required 1", lat); end
      repeat (2) @(negedge clk);
      send_str("5");
      send_byte(8'h0A, lat);
      vectors++; if (trig_mask !== 3'b111) begin miscompares++; $display("FAIL m5_pre_commit: got %b required 111", trig_mask); end
      @(negedge clk);
      vectors++; if (trig_mask !== 3'b101) begin miscompares++; $display("FAIL m5_mask: got %b required 101", trig_mask); end
      vectors++; if (cmd_error !== 1'b0) begin miscompares++; $display("FAIL m5_noerr: got %b required 0", cmd_error); end
      repeat (3) @(negedge clk);
      vectors++; if (uld_cnt - u0 != 3) begin miscompares++; $display("FAIL m5_uld_count: got %0d required 3", uld_cnt - u0); end
      vectors++; if (err_pulses - e0 != 0) begin miscompares++; $display("FAIL m5_err_pulses: got %0d required 0", err_pulses - e0); end
   endtask

   task automatic test_div();
      int e0, lat;
      send_str("D3C\r\n");
      vectors++; if (clk_div !== 8'h3C) begin miscompares++; $display("FAIL d3c_div: got %h required 3c", clk_div); end
      e0 = err_pulses;
      send_str("D3");
      send_byte("G", lat);
      @(negedge clk);
      vectors++; if (cmd_error !== 1'b1) begin miscompares++; $display("FAIL d3g_err_edge: got %b required 1", cmd_error); end
      vectors++; if (state_debug !== 4'd4) begin miscompares++; $display("FAIL d3g_discard: got %0d required 4", state_debug); end
      send_str("\n");
      vectors++; if (clk_div !== 8'h3C) begin miscompares++; $display("FAIL d3g_div_kept: got %h required 3c", clk_div); end
      vectors++; if (err_count !== 8'd1) begin miscompares++; $display("FAIL d3g_errcnt: got %0d required 1", err_count); end
      vectors++; if (err_pulses - e0 != 1) begin miscompares++; $display("FAIL d3g_pulses: got %0d required 1", err_pulses - e0); end
      vectors++; if (state_debug !== 4'd0) begin miscompares++; $display("FAIL d3g_state: got %0d required 0", state_debug); end
   endtask

   task automatic test_strobes();
      int e0 = err_pulses, a0 = arm_cnt, s0 = srst_cnt, lat;
      send_str("A");
      send_byte(8'h0A, lat);
      vectors++; if (arm_pulse !== 1'b0) begin miscompares++; $display("FAIL arm_early: got %b required 0", arm_pulse); end
      @(negedge clk);
      vectors++; if ({arm_pulse, soft_rst_pulse} !== 2'b10) begin miscompares++; $display("FAIL arm_pulse: got %b required 10", {arm_pulse, soft_rst_pulse}); end
      @(negedge clk);
      vectors++; if (arm_pulse !== 1'b0) begin miscompares++; $display("FAIL arm_width: got %b required 0", arm_pulse); end
      send_str("R");
      send_byte(8'h0A, lat);
      @(negedge clk);
      vectors++; if ({arm_pulse, soft_rst_pulse} !== 2'b01) begin miscompares++; $display("FAIL srst_pulse: got %b required 01", {arm_pulse, soft_rst_pulse}); end
      @(negedge clk);
      vectors++; if (soft_rst_pulse !== 1'b0) begin miscompares++; $display("FAIL srst_width: got %b required 0", soft_rst_pulse); end
      send_str("\n");
      repeat (2) @(negedge clk);
      vectors++; if (trig_mask !== 3'b101 || clk_div !== 8'h3C) begin
         miscompares++; $display("FAIL strobe_cfg_kept: got %b/%h required 101/3c", trig_mask, clk_div);
      end
      vectors++; if (err_pulses - e0 != 0) begin miscompares++; $display("FAIL bare_lf_err: got %0d required 0", err_pulses - e0); end
      vectors++; if (arm_cnt - a0 != 1 || srst_cnt - s0 != 1) begin
         miscompares++; $display("FAIL strobe_counts: got %0d/%0d required 1/1", arm_cnt - a0, srst_cnt - s0);
      end
   endtask

   task automatic test_timeout();
      int e0 = err_pulses, first = -1, lat;
      logic [7:0] ec0 = err_count;
      send_byte("M", lat);
      for (int k = 1; k <= 150; k++) begin
         @(negedge clk);
         if (cmd_error && first < 0) first = k - 1;
      end
      fbuf.delete();
      model_err();
      vectors++; if (first != TO_CYC + 1) begin miscompares++; $display("FAIL to_timing: got %0d edges required %0d", first, TO_CYC + 1); end
      vectors++; if (err_pulses - e0 != 1) begin miscompares++; $display("FAIL to_pulses: got %0d required 1", err_pulses - e0); end
      vectors++; if (err_count !== ec0 + 8'd1) begin miscompares++; $display("FAIL to_errcnt: got %0d required %0d", err_count, ec0 + 8'd1); end
      vectors++; if (state_debug !== 4'd0) begin miscompares++; $display("FAIL to_state: got %0d required 0", state_debug); end
      send_str("M2\n");
      vectors++; if (trig_mask !== 3'b010) begin miscompares++; $display("FAIL to_recover: got %b required 010", trig_mask); end
   endtask

   task automatic test_random();
      byte unsigned fr[$];
      int u0 = uld_cnt, e0 = err_pulses, a0 = arm_cnt, s0 = srst_cnt;
      int me0 = m_errs, ma0 = m_arms, ms0 = m_srsts, nbytes = 0, lat, h;
      byte unsigned c;
      for (int f = 0; f < 40; f++) begin
         fr.delete();
         case ($urandom_range(0, 11))
            0: begin fr.push_back("M"); fr.push_back(8'(48 + $urandom_range(0, 7))); end
            1: begin
               fr.push_back("D");
               for (int j = 0; j < 2; j++) begin
                  h = $urandom_range(0, 15);
                  fr.push_back(8'(h < 10 ? 48 + h : 55 + h));
               end
            end
            2: fr.push_back("A");
            3: fr.push_back("R");
            4: begin end
            5: begin fr.push_back("M"); fr.push_back(8'(56 + $urandom_range(0, 1))); end
            6: begin fr.push_back("D"); fr.push_back("7"); fr.push_back(8'(97 + $urandom_range(0, 5))); end
            7: begin
               do c = 8'($urandom_range(65, 90)); while (c == "M" || c == "D" || c == "A" || c == "R");
               fr.push_back(c);
            end
            8: fr.push_back("M");
            9: begin fr.push_back("D"); fr.push_back("B"); end
            10: begin fr.push_back("A"); fr.push_back(8'($urandom_range(48, 90))); end
            default: begin fr.push_back("M"); fr.push_back("1"); fr.push_back("2"); end
         endcase
         fr.push_back(8'h0A);
         foreach (fr[j]) begin
            if ($urandom_range(0, 7) == 0) begin
               send_byte(8'h0D, lat); nbytes++;
               repeat ($urandom_range(1, 4)) @(negedge clk);
            end
            send_byte(fr[j], lat); nbytes++;
            repeat ($urandom_range(1, 4)) @(negedge clk);
         end
         vectors++; if (trig_mask !== m_mask) begin miscompares++; $display("FAIL rnd_mask[%0d]: got %b required %b", f, trig_mask, m_mask); end
         vectors++; if (clk_div !== m_div) begin miscompares++; $display("FAIL rnd_div[%0d]: got %h required %h", f, clk_div, m_div); end
         vectors++; if (err_count !== m_errcnt) begin miscompares++; $display("FAIL rnd_errcnt[%0d]: got %0d required %0d", f, err_count, m_errcnt); end
      end
      repeat (2) @(negedge clk);
      vectors++; if (err_pulses - e0 != m_errs - me0) begin miscompares++; $display("FAIL rnd_err_pulses: got %0d required %0d", err_pulses - e0, m_errs - me0); end
      vectors++; if (arm_cnt - a0 != m_arms - ma0) begin miscompares++; $display("FAIL rnd_arms: got %0d required %0d", arm_cnt - a0, m_arms - ma0); end
      vectors++; if (srst_cnt - s0 != m_srsts - ms0) begin miscompares++; $display("FAIL rnd_srsts: got %0d required %0d", srst_cnt - s0, m_srsts - ms0); end
      vectors++; if (uld_cnt - u0 != nbytes) begin miscompares++; $display("FAIL rnd_uld: got %0d required %0d", uld_cnt - u0, nbytes); end
   endtask

   task automatic test_saturation();
      int e0 = err_pulses;
      for (int i = 0; i < 300; i++) send_str("X\n");
      vectors++; if (err_count !== 8'd255) begin miscompares++; $display("FAIL sat_errcnt: got %0d required 255", err_count); end
      vectors++; if (err_pulses - e0 != 300) begin miscompares++; $display("FAIL sat_pulses: got %0d required 300", err_pulses - e0); end
   endtask

   task automatic test_midframe_reset();
      int e0, a0, s0;
      send_str("D4");
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
      e0 = err_pulses; a0 = arm_cnt; s0 = srst_cnt;
      send_str("\n");
      repeat (2) @(negedge clk);
      vectors++; if (clk_div !== 8'h00) begin miscompares++; $display("FAIL mrst_div: got %h required 00", clk_div); end
      vectors++; if (err_count !== 8'h00) begin miscompares++; $display("FAIL mrst_errcnt: got %0d required 0", err_count); end
      vectors++; if (trig_mask !== 3'b111) begin miscompares++; $display("FAIL mrst_mask: got %b required 111", trig_mask); end
      vectors++; if (err_pulses != e0 || arm_cnt != a0 || srst_cnt != s0) begin
         miscompares++; $display("FAIL mrst_pulses: got %0d/%0d/%0d required 0/0/0", err_pulses - e0, arm_cnt - a0, srst_cnt - s0);
      end
      vectors++; if (bad_uld != 0) begin miscompares++; $display("FAIL uld_while_empty: got %0d required 0", bad_uld); end
      vectors++; if (bad_pulse != 0) begin miscompares++; $display("FAIL strobe_width: got %0d wide strobes required 0", bad_pulse); end
   endtask

   initial begin
      test_reset();
      test_mask();
      test_div();
      test_strobes();
      test_timeout();
      test_random();
      test_saturation();
      test_midframe_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: run exceeded 5 ms, required completion");
      $fatal(1, "watchdog");
   end

endmodule
